// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } resp_state_e;

endpackage

// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite slave-side bus bundle: master address/control/write data in,
// completion, response and read data out.
interface ahb_mem_responder_if;
    import ahb_pkg::*;

    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        input  hready, hwdata,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        output hwdata,
        input  hready, hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_byte_strobe.sv
// Maps transfer size and the low address bits to the byte lanes touched.
// Unsupported sizes enable no lanes.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    // Lane decode: byte picks one lane, half picks a lane pair, word all four.
    always_comb begin
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: word-organised register memory with fixed
// wait-state insertion on OKAY beats and a two-cycle ERROR response.
module ahb_mem_responder
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 1
)
(
    input  logic               hclk,
    input  logic               hreset,
    ahb_mem_responder_if.slave bus
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int AW    = ADDR_W + 2;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q;
    logic              wr_q;
    logic [2:0]        size_q;
    logic [31:0]       mem [DEPTH];

    logic              can_accept;
    logic              accept;
    logic              req_err;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] idx;
    logic              unused_bus;

    // Burst type, protection and lock have no effect on a plain memory;
    // htrans[0] only separates NONSEQ from SEQ, which are treated alike.
    assign unused_bus = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

    // Address-phase signals are only looked at when no data phase is stalling.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign accept     = can_accept & bus.hsel & bus.hready & bus.htrans[1];

    // Out-of-range, unsupported-size or misaligned requests get ERROR.
    always_comb begin
        req_err = |bus.haddr[31:AW];
        case (bus.hsize)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (bus.haddr[0]) req_err = 1'b1;
            HSIZE_WORD: if (|bus.haddr[1:0]) req_err = 1'b1;
            default:    req_err = 1'b1;
        endcase
    end

    // Next-state and wait-counter logic; IDLE/DONE/ERR2 re-enter on a new accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the address phase of every accepted transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            size_q <= HSIZE_BYTE;
        end else if (accept) begin
            addr_q <= bus.haddr[AW-1:0];
            wr_q   <= bus.hwrite;
            size_q <= bus.hsize;
        end
    end

    assign idx = addr_q[AW-1:2];

    ahb_byte_strobe u_strobe (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .strb    (strb)
    );

    // Memory: cleared by reset, written lane-wise on the completing OKAY edge.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state_q == ST_DONE && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata    = (!wr_q && ((state_q == ST_WAIT) || (state_q == ST_DONE))) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Bench for ahb_mem_responder: two instances (WAIT_STATES=1 and 0) behind a
// shared master model; expected beats go into a scoreboard when driven and
// are retired when the selected responder completes the data phase.
module tb_ahb_mem_responder;
    import ahb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        sel;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    int          checks = 0;
    int          errors = 0;
    int          sel = 1;

    logic        d_hsel;
    logic [31:0] d_haddr;
    logic        d_hwrite;
    logic [2:0]  d_hsize;
    logic [1:0]  d_htrans;
    logic [31:0] d_hwdata;

    logic [31:0] model [2][64];
    beat_t       stim [$];
    exp_t        sb [$];

    always #5 hclk = ~hclk;

    ahb_mem_responder_if bus1 ();
    ahb_mem_responder_if bus0 ();

    assign bus1.hsel      = d_hsel && (sel == 1);
    assign bus1.haddr     = d_haddr;
    assign bus1.hwrite    = d_hwrite;
    assign bus1.hsize     = d_hsize;
    assign bus1.hburst    = 3'b001;
    assign bus1.hprot     = 4'b0011;
    assign bus1.htrans    = d_htrans;
    assign bus1.hmastlock = 1'b0;
    assign bus1.hready    = bus1.hreadyout;
    assign bus1.hwdata    = d_hwdata;

    assign bus0.hsel      = d_hsel && (sel == 0);
    assign bus0.haddr     = d_haddr;
    assign bus0.hwrite    = d_hwrite;
    assign bus0.hsize     = d_hsize;
    assign bus0.hburst    = 3'b011;
    assign bus0.hprot     = 4'b0011;
    assign bus0.htrans    = d_htrans;
    assign bus0.hmastlock = 1'b0;
    assign bus0.hready    = bus0.hreadyout;
    assign bus0.hwdata    = d_hwdata;

    logic        o_ready, o_resp;
    logic [31:0] o_rdata;
    assign o_ready = (sel == 1) ? bus1.hreadyout : bus0.hreadyout;
    assign o_resp  = (sel == 1) ? bus1.hresp     : bus0.hresp;
    assign o_rdata = (sel == 1) ? bus1.hrdata    : bus0.hrdata;

    ahb_mem_responder #(.ADDR_W(6), .WAIT_STATES(1)) dut1 (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus1)
    );

    ahb_mem_responder #(.ADDR_W(6), .WAIT_STATES(0)) dut0 (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus0)
    );

    task automatic drive_idle();
        d_hsel   = 1'b0;
        d_haddr  = 32'h0;
        d_hwrite = 1'b0;
        d_hsize  = HSIZE_BYTE;
        d_htrans = HTRANS_IDLE;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) model[s][i] = 32'h0;
    endtask

    // 64 words = 256 bytes; alignment is address modulo the transfer size.
    function automatic logic exp_error(input beat_t b);
        if (b.addr >= 32'd256) return 1'b1;
        if (b.size > 3'd2) return 1'b1;
        if ((b.addr % (32'd1 << b.size)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr = HTRANS_NONSEQ,
                       input logic hs = 1'b1);
        beat_t b;
        b.addr = a; b.wr = w; b.size = sz; b.wdata = wd; b.trans = tr; b.sel = hs;
        stim.push_back(b);
    endtask

    task automatic push_exp(input beat_t b);
        exp_t e;
        int   idx, off, n;
        e.wr     = b.wr;
        e.err    = exp_error(b);
        e.cycles = e.err ? 2 : ((sel == 1) ? 2 : 1);
        idx = int'(b.addr[7:2]);
        off = int'(b.addr[1:0]);
        n   = 1 << b.size;
        if (!e.err && b.wr) begin
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + n) model[sel][idx][8*i +: 8] = b.wdata[8*i +: 8];
        end
        e.rdata = (!e.err && !b.wr) ? model[sel][idx] : 32'h0;
        sb.push_back(e);
    endtask

    // Pipelined master: address phase of the next beat overlaps the data
    // phase of the current one. Entered and left just after a rising edge.
    task automatic run_seq(input string name);
        beat_t ap, dpb;
        logic  ap_v = 1'b0, dp_v = 1'b0, rdy;
        int    dp_cyc = 0, guard = 0;
        while ((stim.size() > 0 || ap_v || dp_v) && guard < 200) begin
            guard++;
            if (!ap_v && stim.size() > 0) begin
                ap   = stim.pop_front();
                ap_v = 1'b1;
                if (ap.sel && ap.trans[1]) push_exp(ap);
            end
            if (ap_v) begin
                d_hsel = ap.sel; d_haddr = ap.addr; d_hwrite = ap.wr;
                d_hsize = ap.size; d_htrans = ap.trans;
            end else begin
                drive_idle();
            end
            d_hwdata = dp_v ? dpb.wdata : 32'h0;
            @(negedge hclk);
            rdy = o_ready;
            if (dp_v) begin
                dp_cyc++;
                checks++;
                if (o_resp !== sb[0].err) begin
                    errors++;
                    $display("FAIL %s hresp: got %0b want %0b (addr %h)", name, o_resp, sb[0].err, dpb.addr);
                end
                checks++;
                if (o_rdata !== sb[0].rdata) begin
                    errors++;
                    $display("FAIL %s hrdata: got %h want %h (addr %h)", name, o_rdata, sb[0].rdata, dpb.addr);
                end
                if (rdy) begin
                    checks++;
                    if (dp_cyc != sb[0].cycles) begin
                        errors++;
                        $display("FAIL %s latency: got %0d want %0d cycles (addr %h)", name, dp_cyc, sb[0].cycles, dpb.addr);
                    end
                    void'(sb.pop_front());
                    dp_v = 1'b0;
                end
            end else begin
                checks++;
                if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL %s idle: got ready=%b resp=%b rdata=%h want 1/0/0", name, o_ready, o_resp, o_rdata);
                end
            end
            @(posedge hclk);
            #1;
            if (rdy && ap_v) begin
                if (ap.sel && ap.trans[1]) begin
                    dp_v = 1'b1; dpb = ap; dp_cyc = 0;
                end
                ap_v = 1'b0;
            end
        end
        drive_idle();
        d_hwdata = 32'h0;
        if (guard >= 200) begin
            errors++;
            $display("FAIL %s timeout: %0d beats still pending, want 0", name, sb.size());
            sb.delete();
            stim.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checks++;
        if (bus1.hreadyout !== 1'b1 || bus1.hresp !== 1'b0 || bus1.hrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset ws1: got ready=%b resp=%b rdata=%h want 1/0/0", bus1.hreadyout, bus1.hresp, bus1.hrdata);
        end
        checks++;
        if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b0 || bus0.hrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset ws0: got ready=%b resp=%b rdata=%h want 1/0/0", bus0.hreadyout, bus0.hresp, bus0.hrdata);
        end
        hreset = 1'b0;
        @(posedge hclk);
        #1;
    endtask

    task automatic test_word_rw();
        sel = 1;
        add(32'h10, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        add(32'h10, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h14, 1'b1, HSIZE_WORD, 32'hCAFEF00D, HTRANS_SEQ);
        add(32'h14, 1'b0, HSIZE_WORD, 32'h0);
        run_seq("word_rw");
    endtask

    task automatic test_byte_lanes();
        sel = 1;
        add(32'h0, 1'b1, HSIZE_WORD, 32'h11223344);
        add(32'h2, 1'b1, HSIZE_BYTE, 32'h00AA0000);
        add(32'h0, 1'b1, HSIZE_HALF, 32'h0000BBCC);
        add(32'h0, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h4, 1'b1, HSIZE_WORD, 32'h01020304);
        add(32'h6, 1'b1, HSIZE_HALF, 32'h55660000);
        add(32'h7, 1'b1, HSIZE_BYTE, 32'h77000000);
        add(32'h5, 1'b1, HSIZE_BYTE, 32'h00009900);
        add(32'h5, 1'b0, HSIZE_BYTE, 32'h0);
        run_seq("byte_lanes");
    endtask

    task automatic test_errors();
        sel = 1;
        add(32'h100, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h2,   1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        add(32'h1,   1'b1, HSIZE_HALF, 32'hFFFFFFFF);
        add(32'h0,   1'b1, 3'd3,       32'hFFFFFFFF);
        add(32'h0,   1'b0, HSIZE_WORD, 32'h0);
        add(32'h4,   1'b0, HSIZE_WORD, 32'h0);
        run_seq("errors_ws1");
        sel = 0;
        add(32'h0,    1'b1, HSIZE_WORD, 32'h0BADF00D);
        add(32'h1FC,  1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        add(32'h0,    1'b0, HSIZE_WORD, 32'h0);
        run_seq("errors_ws0");
    endtask

    task automatic test_no_accept();
        sel = 1;
        add(32'h10, 1'b1, HSIZE_WORD, 32'h12121212, HTRANS_NONSEQ, 1'b0);
        add(32'h10, 1'b1, HSIZE_WORD, 32'h34343434, HTRANS_IDLE);
        add(32'h10, 1'b1, HSIZE_WORD, 32'h56565656, HTRANS_BUSY);
        add(32'h10, 1'b0, HSIZE_WORD, 32'h0);
        run_seq("no_accept");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        add(32'h20, 1'b1, HSIZE_WORD, 32'hA0A0A0A0, HTRANS_NONSEQ);
        add(32'h24, 1'b1, HSIZE_WORD, 32'hB1B1B1B1, HTRANS_SEQ);
        add(32'h28, 1'b1, HSIZE_WORD, 32'hC2C2C2C2, HTRANS_SEQ);
        add(32'h2C, 1'b1, HSIZE_WORD, 32'hD3D3D3D3, HTRANS_SEQ);
        add(32'h20, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ);
        add(32'h24, 1'b0, HSIZE_WORD, 32'h0, HTRANS_SEQ);
        add(32'h28, 1'b0, HSIZE_WORD, 32'h0, HTRANS_SEQ);
        add(32'h2C, 1'b0, HSIZE_WORD, 32'h0, HTRANS_SEQ);
        add(32'h30, 1'b1, HSIZE_HALF, 32'hFFFF7654);
        add(32'h30, 1'b0, HSIZE_WORD, 32'h0);
        run_seq("back_to_back");
    endtask

    task automatic test_reset_mid_write();
        sel = 1;
        add(32'h30, 1'b1, HSIZE_WORD, 32'hA5A5A5A5);
        run_seq("pre_reset");
        d_hsel = 1'b1; d_haddr = 32'h30; d_hwrite = 1'b1;
        d_hsize = HSIZE_WORD; d_htrans = HTRANS_NONSEQ;
        @(posedge hclk);
        #1;
        drive_idle();
        d_hwdata = 32'h12345678;
        @(negedge hclk);
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset wait: got ready=%b want 0", o_ready);
        end
        hreset = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset outputs: got ready=%b resp=%b rdata=%h want 1/0/0", o_ready, o_resp, o_rdata);
        end
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        d_hwdata = 32'h0;
        clear_model();
        @(posedge hclk);
        #1;
        add(32'h30, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h10, 1'b0, HSIZE_WORD, 32'h0);
        run_seq("post_reset_ws1");
        sel = 0;
        add(32'h20, 1'b0, HSIZE_WORD, 32'h0);
        run_seq("post_reset_ws0");
    endtask

    initial begin
        hreset = 1'b1;
        drive_idle();
        d_hwdata = 32'h0;
        clear_model();
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_errors();
        test_no_accept();
        test_back_to_back();
        test_reset_mid_write();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
